dac_tgc_seq: RTL and testbench
==============================

# dac_tgc_seq

Time-gain-compensation sequencer that drives the DAC controller's `din`/`dvalid` input. It sits between the register/control logic and the DAC SPI controller. It replays a programmable table of DAC codes at a fixed cycle interval after each acquisition trigger, then parks the DAC at an idle code. It honours the controller's `busy` flag and reports late updates.

## Interface
- `DATA_W`, 10, DAC code width (matches the DAC controller).
- `DEPTH`, 32, gain table entries.
- `ADDR_W`, 5, table address width; `2**ADDR_W >= DEPTH`.
- `IVL_W`, 16, interval counter width.

- `clk`  in  1  system clock (64 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `tbl_we`  in  1  table write strobe.
- `tbl_waddr`  in  ADDR_W  table write address.
- `tbl_wdata`  in  DATA_W  table write data.
- `len`  in  ADDR_W+1  points per sweep, 1..DEPTH; sampled at start.
- `interval`  in  IVL_W  cycles between points, ≥2; sampled at start.
- `idle_code`  in  DATA_W  park code; sampled at park issue.
- `start`  in  1  sweep trigger pulse.
- `abort`  in  1  stop sweep and park.
- `dac_din`  out  DATA_W  code to the DAC controller.
- `dac_dvalid`  out  1  one-cycle load strobe to the DAC controller.
- `dac_busy`  in  1  DAC controller busy.
- `running`  out  1  sweep or park in progress.
- `done`  out  1  one-cycle pulse when park completes.
- `overrun`  out  1  sticky: a point was issued late; cleared by next accepted `start`.

## Operation
- Table: DEPTH×DATA_W registers with a synchronous write port, writable in any state. A write to an entry not yet fetched in the current sweep takes effect in that sweep.
- States: IDLE, FETCH, ISSUE, WAIT, PARK, DRAIN.
- IDLE: on `start` with `1 ≤ len ≤ DEPTH`, `interval ≥ 2` and `abort` low:
  - latch `len`/`interval`, clear `overrun`, set index 0, enter FETCH;
  - otherwise `start` is ignored and no state changes.
- FETCH: register `table[index]` into `dac_din`; enter ISSUE.
- ISSUE:
  - if `dac_busy` is low, pulse `dac_dvalid` for one cycle and go to WAIT;
  - if `dac_busy` is high, hold and retry each cycle.
- WAIT: the interval counter runs continuously from sweep start and is not restarted by late issues (no drift). At the next scheduled tick:
  - if index < len-1: increment index, go to FETCH;
  - else go to PARK.
- Late issue: if a point's `dac_dvalid` falls after its scheduled cycle, set `overrun`. If the next tick arrives while still in ISSUE, skip that point's slot (see Timing).
- PARK: `dac_din` ← `idle_code`; issue with the same busy rule as ISSUE; go to DRAIN.
- DRAIN: when `dac_busy` is low (earliest 2 cycles after the park strobe), pulse `done` and go to IDLE.
- `abort` in FETCH/ISSUE/WAIT: next cycle go to PARK; a pending point is not issued. `abort` in PARK/DRAIN/IDLE is ignored.
- `start` is ignored while `running` is high.
- `running` is high in every state except IDLE.

## Timing
- Reset values: `dac_din`=0, `dac_dvalid`=0, `running`=0, `done`=0, `overrun`=0; state IDLE; index 0; counter 0.
- `start` sampled at edge T0.
- Point k is scheduled at T0+2+k·`interval`. Its `dac_dvalid` is high in the cycle after that edge when `dac_busy` is low.
- Park is scheduled at T0+2+len·`interval`.
- If point k is still unissued when point k+1's tick arrives: issue k immediately, and issue k+1 at the following free opportunity. Points are never dropped except on abort.
- `done` rises one cycle after `dac_busy` is first seen low in DRAIN.
- `overrun` updates in the same cycle as the late `dac_dvalid`.
- Reset asserted mid-sweep: outputs go to reset values asynchronously; no partial strobe is generated.

## Test plan
- Write table[0..3]={0x010,0x100,0x200,0x3FF}; `len`=4, `interval`=200, `dac_busy` model clears 60 cycles after each strobe; `start` at T0 -> strobes at T0+2/202/402/602 with those codes, park with `idle_code`=0x000 at T0+802, `done` once, `overrun`=0.
- Same setup with `interval`=40 and busy lasting 60 cycles -> every point is still issued, in order; `overrun`=1 after the first late issue; the next `start` clears it.
- `abort` at T0+300 with `len`=4 -> no further table strobes; park strobe with `idle_code` within 3 cycles (busy low); `done` follows.
- `start` with `len`=0, then `start` with `interval`=1, then `start` while `running` -> no `dac_dvalid`; state unchanged.
- Write table[3]=0x2AA during the sweep before point 3 is fetched -> point 3 carries 0x2AA.
- Deassert `rst_n` in WAIT -> all outputs 0 immediately; after release, a `start` performs a clean full sweep.

Source files
------------

// File: rtl/dac_tgc_seq_if.sv
// DAC controller load port: code, one-cycle load strobe and busy return.
interface dac_tgc_seq_if #(
  parameter int unsigned DATA_W = 10
);
  logic [DATA_W-1:0] dac_din;
  logic              dac_dvalid;
  logic              dac_busy;

  modport master (output dac_din, output dac_dvalid, input dac_busy);
  modport slave  (input dac_din, input dac_dvalid, output dac_busy);
endinterface

// File: rtl/dac_tgc_seq.sv
// TGC sequencer: replays a gain table to the DAC controller on a fixed
// interval grid after each trigger, then parks the DAC at an idle code.
module dac_tgc_seq #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned IVL_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_waddr,
  input  logic [DATA_W-1:0] tbl_wdata,
  input  logic [ADDR_W:0]   len,
  input  logic [IVL_W-1:0]  interval,
  input  logic [DATA_W-1:0] idle_code,
  input  logic              start,
  input  logic              abort,
  dac_tgc_seq_if.master     dac,
  output logic              running,
  output logic              done,
  output logic              overrun
);

  localparam int unsigned     PEND_W  = ADDR_W + 2;
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_PARK, S_DRAIN
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_tbl [DEPTH];
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W:0]     r_len;
  logic [IVL_W-1:0]    r_ivl;
  logic [IVL_W-1:0]    r_cnt;
  logic [PEND_W-1:0]   r_pend;
  logic                r_late;
  logic                r_step;
  logic [DATA_W-1:0]   r_din;
  logic                r_dvalid;
  logic                r_running;
  logic                r_done;
  logic                r_overrun;

  logic                w_tick;
  logic                w_last;
  logic                w_start_ok;
  logic [PEND_W-1:0]   w_pend_inc;

  always_ff @(posedge clk) begin
    if (tbl_we) r_tbl[tbl_waddr] <= tbl_wdata;
  end

  always_comb begin
    w_tick     = (r_cnt == r_ivl - IVL_W'(1));
    w_last     = ({1'b0, r_idx} == r_len - LEN_ONE);
    w_start_ok = start && !abort && (len != '0) && (len <= LEN_MAX) &&
                 (interval >= IVL_W'(2));
    w_pend_inc = r_pend;
    if (w_tick && (r_pend != '1)) w_pend_inc = r_pend + PEND_W'(1);
  end

  // r_pend counts grid ticks not yet consumed by WAIT, so late points are
  // issued back-to-back without shifting the grid; r_late marks a point
  // released from backlog or held by busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_ivl     <= '0;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_late    <= 1'b0;
      r_step    <= 1'b0;
      r_din     <= '0;
      r_dvalid  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_dvalid <= 1'b0;
      r_done   <= 1'b0;
      if (r_state != S_IDLE) r_cnt <= w_tick ? '0 : r_cnt + IVL_W'(1);
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_len     <= len;
            r_ivl     <= interval;
            r_overrun <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_pend    <= '0;
            r_late    <= 1'b0;
            r_running <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (abort) r_state <= S_PARK;
          else begin
            r_din   <= r_tbl[r_idx];
            r_pend  <= w_pend_inc;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) r_state <= S_PARK;
          else begin
            r_pend <= w_pend_inc;
            if (!dac.dac_busy) begin
              r_dvalid  <= 1'b1;
              r_overrun <= r_overrun | r_late;
              r_state   <= S_WAIT;
            end else begin
              r_late <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (abort) r_state <= S_PARK;
          else if (w_pend_inc != '0) begin
            r_pend <= w_pend_inc - PEND_W'(1);
            r_late <= (r_pend != '0);
            if (w_last) r_state <= S_PARK;
            else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        // First cycle in PARK/DRAIN is a settle slot; the controller has not
        // yet had a chance to raise busy in response to the previous strobe.
        S_PARK: begin
          if (!r_step) r_step <= 1'b1;
          else if (!dac.dac_busy) begin
            r_din    <= idle_code;
            r_dvalid <= 1'b1;
            r_step   <= 1'b0;
            r_state  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_step) r_step <= 1'b1;
          else if (!dac.dac_busy) begin
            r_done    <= 1'b1;
            r_running <= 1'b0;
            r_step    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dac.dac_din    = r_din;
  assign dac.dac_dvalid = r_dvalid;
  assign running        = r_running;
  assign done           = r_done;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_dac_tgc_seq.sv
// Directed bench for dac_tgc_seq with a busy model that holds busy for a
// fixed number of cycles after each load strobe.
module tb_dac_tgc_seq;
  localparam int BUSY_LEN = 60;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_we;
  logic [4:0]  tbl_waddr;
  logic [9:0]  tbl_wdata;
  logic [5:0]  len;
  logic [15:0] interval;
  logic [9:0]  idle_code;
  logic        start;
  logic        abort;
  logic        running;
  logic        done;
  logic        overrun;

  dac_tgc_seq_if #(.DATA_W(10)) dac_if ();

  dac_tgc_seq #(
    .DATA_W(10),
    .DEPTH (32),
    .ADDR_W(5),
    .IVL_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tbl_we   (tbl_we),
    .tbl_waddr(tbl_waddr),
    .tbl_wdata(tbl_wdata),
    .len      (len),
    .interval (interval),
    .idle_code(idle_code),
    .start    (start),
    .abort    (abort),
    .dac      (dac_if),
    .running  (running),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic [9:0] code;
  } strobe_t;

  int      cyc = 0;
  int      t0 = 0;
  int      n_chk = 0;
  int      n_fail = 0;
  logic    busy_m = 1'b0;
  int      busy_cnt = 0;
  strobe_t sq[$];
  int      done_t[$];
  int      exp_t[5];
  int      exp_c[5];
  int      v_len[4];
  int      v_ivl[4];
  logic    v_ab[4];

  assign dac_if.dac_busy = busy_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and busy model, both evaluated away from the active edge.
  always @(negedge clk) begin
    if (dac_if.dac_dvalid) sq.push_back('{t: cyc - t0, code: dac_if.dac_din});
    if (done) done_t.push_back(cyc - t0);
    if (dac_if.dac_dvalid) begin
      busy_m   = 1'b1;
      busy_cnt = BUSY_LEN;
    end else if (busy_m) begin
      busy_cnt = busy_cnt - 1;
      if (busy_cnt == 0) busy_m = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " dvalid"},  32'(dac_if.dac_dvalid), 0);
    check({tag, " din"},     32'(dac_if.dac_din), 0);
    check({tag, " running"}, 32'(running), 0);
    check({tag, " done"},    32'(done), 0);
    check({tag, " overrun"}, 32'(overrun), 0);
  endtask

  task automatic tbl_write(input int addr, input int data);
    @(negedge clk);
    tbl_we    = 1'b1;
    tbl_waddr = 5'(addr);
    tbl_wdata = 10'(data);
    @(negedge clk);
    tbl_we    = 1'b0;
  endtask

  task automatic start_sweep(input int l, input int ivl, input int idle);
    @(negedge clk);
    len       = 6'(l);
    interval  = 16'(ivl);
    idle_code = 10'(idle);
    sq.delete();
    done_t.delete();
    t0        = cyc + 1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_off(input int n);
    while (cyc - t0 < n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (running && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " running clears"}, 32'(running), 0);
    @(negedge clk);
  endtask

  task automatic expect_sweep(input string tag, input int n, input int done_off);
    check({tag, " strobe count"}, sq.size(), n);
    for (int i = 0; i < n && i < sq.size(); i++) begin
      check($sformatf("%s p%0d time", tag, i), sq[i].t, exp_t[i]);
      check($sformatf("%s p%0d code", tag, i), 32'(sq[i].code), exp_c[i]);
    end
    check({tag, " done count"}, done_t.size(), 1);
    if (done_t.size() > 0) check({tag, " done time"}, done_t[0], done_off);
  endtask

  initial begin
    rst_n     = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = '0;
    len       = '0;
    interval  = '0;
    idle_code = '0;
    start     = 1'b0;
    abort     = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tbl_write(0, 'h010);
    tbl_write(1, 'h100);
    tbl_write(2, 'h200);
    tbl_write(3, 'h3FF);

    // Nominal sweep: every point on the grid.
    start_sweep(4, 200, 'h000);
    wait_idle("nominal");
    exp_t = '{2, 202, 402, 602, 802};
    exp_c = '{'h010, 'h100, 'h200, 'h3FF, 'h000};
    expect_sweep("nominal", 5, 863);
    check("nominal overrun", 32'(overrun), 0);

    // Interval shorter than busy: points pile up but all go out in order.
    start_sweep(4, 40, 'h000);
    wait_idle("late");
    exp_t = '{2, 63, 124, 185, 246};
    exp_c = '{'h010, 'h100, 'h200, 'h3FF, 'h000};
    expect_sweep("late", 5, 307);
    check("late overrun set", 32'(overrun), 1);

    // Abort mid-sweep; the accepted start also clears overrun.
    start_sweep(4, 200, 'h155);
    check("start clears overrun", 32'(overrun), 0);
    wait_off(299);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle("abort");
    exp_t = '{2, 202, 302, 0, 0};
    exp_c = '{'h010, 'h100, 'h155, 0, 0};
    expect_sweep("abort", 3, 363);

    // Rejected triggers.
    v_len = '{0, 4, 33, 4};
    v_ivl = '{200, 1, 200, 200};
    v_ab  = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sq.delete();
      len      = 6'(v_len[i]);
      interval = 16'(v_ivl[i]);
      abort    = v_ab[i];
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      abort    = 1'b0;
      repeat (4) @(negedge clk);
      check($sformatf("reject%0d running", i), 32'(running), 0);
      check($sformatf("reject%0d strobes", i), sq.size(), 0);
    end

    // Re-trigger while running is ignored; a late table write is picked up.
    start_sweep(4, 200, 'h000);
    wait_off(50);
    len      = 6'd2;
    interval = 16'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_off(100);
    tbl_write(3, 'h2AA);
    wait_idle("rewrite");
    exp_t = '{2, 202, 402, 602, 802};
    exp_c = '{'h010, 'h100, 'h200, 'h2AA, 'h000};
    expect_sweep("rewrite", 5, 863);
    check("rewrite overrun", 32'(overrun), 0);

    // Reset during WAIT, then a clean sweep.
    start_sweep(4, 200, 'h000);
    wait_off(100);
    check("pre-reset running", 32'(running), 1);
    check("pre-reset din", 32'(dac_if.dac_din), 'h010);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_sweep(4, 200, 'h000);
    wait_idle("post-reset");
    exp_t = '{2, 202, 402, 602, 802};
    exp_c = '{'h010, 'h100, 'h200, 'h2AA, 'h000};
    expect_sweep("post-reset", 5, 863);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
